mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-side counterpart of the writeback source mux. It produces the `mem_data` word that writeback selects when `mem_to_reg` = 1.
- Accepts one load/store request per instruction from the execute stage: opcode, funct3, ALU address, rs2 data.
- Drives a request/acknowledge data-memory bus with byte enables and lane-replicated store data.
- Returns the load result sign/zero-extended, stalls the pipeline while the bus is outstanding, and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT, 255, bus cycles to wait for `mem_ack` before abandoning the access (1..255; counter is 8 bits).

Ports:
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe from execute stage, qualified by opcode.
- `opcode`  in  7  instruction opcode (0000011 load, 0100011 store).
- `funct3`  in  3  access size/sign field.
- `addr`  in  32  byte address (ALU result).
- `store_data`  in  32  rs2 value for stores.
- `busy`  out  1  stall to pipeline; high while a bus access is outstanding.
- `done`  out  1  one-cycle completion pulse (normal or fault).
- `fault`  out  1  valid with `done`: misaligned, illegal funct3, or timeout.
- `load_data`  out  32  formatted load result to writeback `mem_data`.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address ({addr[31:2],2'b00}).
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  write data, lane-replicated.
- `mem_rdata`  in  32  read data, valid when `mem_ack` = 1.
- `mem_ack`  in  1  bus acknowledge.

Behaviour:
- **Reset values:** all outputs 0, including `load_data`. State IDLE, timeout counter 0.
- **States:**
  - IDLE: waiting for a request.
  - BUS: `mem_req` = 1, counting cycles.
  - RESP: `done` = 1 for one cycle.
  - `busy` = 1 exactly in BUS.
- **Accept:** `start` is sampled only in IDLE or RESP, and only with opcode 0000011 or 0100011.
  - Other opcodes are ignored: no state change, no `done`.
  - `start` in BUS is ignored.
- **Legal access** (accepted in cycle N):
  - Enter BUS at N+1. `mem_req`/`mem_we`/`mem_addr`/`mem_be`/`mem_wdata` are registered at N and held constant through BUS.
  - Counter is cleared on entry and increments each BUS cycle.
- **Acknowledge:** `mem_ack` sampled high in BUS cycle M goes to RESP at M+1 with `mem_req` = 0, `done` = 1, `fault` = 0.
  - For loads, `load_data` is registered at M from `mem_rdata`.
  - Minimum start-to-done latency is 2 cycles.
  - `mem_ack` outside BUS is ignored.
- **Timeout:** if the counter reaches TIMEOUT without ack, go to RESP with `done` = 1, `fault` = 1, `mem_req` = 0. `load_data` is unchanged.
- **Pre-bus faults:** illegal or misaligned requests never assert `mem_req`. They go directly to RESP at N+1 with `fault` = 1.
  - Misaligned: halfword with addr[0] = 1; word with addr[1:0] ≠ 0.
  - Illegal funct3, load: 011, 110, 111.
  - Illegal funct3, store: anything other than 000, 001, 010.
- **Store encoding** (o = addr[1:0]):
  - SB: `mem_be` = 4'b0001 << o; `mem_wdata` = byte replicated 4×.
  - SH: `mem_be` = 4'b0011 << o; `mem_wdata` = halfword replicated 2×.
  - SW: `mem_be` = 4'b1111; `mem_wdata` = `store_data`.
- **Load encoding:** `mem_be` = same lane pattern as stores; `mem_we` = 0. The lane is selected from `mem_rdata` by o.
  - LB: sign-extend the byte.
  - LBU: zero-extend the byte.
  - LH: sign-extend the halfword.
  - LHU: zero-extend the halfword.
  - LW: the full word.
- **`load_data` hold:** holds its value until the next successful load. Stores and faults do not alter it.
- **Back-to-back:** `start` in a RESP cycle begins the next access, entering BUS or RESP on the following cycle; no idle bubble is required.
- **Reset mid-operation:** `rst` in any state forces IDLE and zero outputs on the next edge. A late `mem_ack` after reset is ignored.

Test Plan:
- **LW:** LW addr 0x100; memory acks 3 cycles after `mem_req` with rdata 0xDEADBEEF.
  - Expect `mem_addr` = 0x100, `mem_be` = 1111, `mem_we` = 0, `busy` for 3 cycles, then `done` = 1, `fault` = 0, `load_data` = 0xDEADBEEF.
- **LB vs LBU:** LB addr 0x103, rdata 0x80FF1234 → `mem_be` = 1000, `load_data` = 0xFFFFFF80. LBU at the same address → 0x00000080.
- **SH:** addr 0x202, `store_data` 0x0000ABCD, immediate ack → `mem_we` = 1, `mem_addr` = 0x200, `mem_be` = 1100, `mem_wdata` = 0xABCDABCD, `done` 2 cycles after `start`. `load_data` unchanged.
- **Faults:**
  - LW at 0x101 → no `mem_req`; `done` and `fault` at N+1.
  - Load with funct3 011 → same response.
  - Opcode 0110011 with `start` → nothing happens.
- **Timeout:** TIMEOUT = 4, SW with ack never asserted → `mem_req` high 4 cycles, then `done` = 1, `fault` = 1, `mem_req` = 0. A later stray ack has no effect.
- **Reset mid-operation:** `rst` pulsed in the 2nd BUS cycle → next cycle all outputs 0; ack the following cycle produces no `done`. A new SW afterwards completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine. Takes one request per
// instruction from execute, drives a req/ack data bus with byte enables and
// lane-replicated store data, and returns the formatted load word that
// writeback selects as mem_data. Faults (misaligned, illegal size, timeout)
// complete with a one-cycle done pulse carrying fault = 1.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  count;
    logic [2:0]  pend_funct3;
    logic [1:0]  pend_offset;
    logic        is_load;
    logic        is_store;
    logic        accept;
    logic        funct3_ok;
    logic        aligned;
    logic        legal;
    logic        timed_out;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] lane;
    logic [31:0] load_fmt;

    // Decode the incoming request: acceptance, legality and bus lane encoding.
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        accept   = start && (is_load || is_store) && (state == IDLE || state == RESP);
        if (is_store)
            funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        else
            funct3_ok = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        case (funct3[1:0])
            2'b01:   aligned = ~addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        legal = funct3_ok && aligned;
        case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << addr[1:0];
                wdata_calc = {2{store_data[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = store_data;
            end
        endcase
    end

    // Shift the addressed lane down and sign/zero-extend it for writeback.
    always_comb begin
        lane = mem_rdata >> {pend_offset, 3'b000};
        case (pend_funct3)
            3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_fmt = {24'h000000, lane[7:0]};
            3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_fmt = {16'h0000, lane[15:0]};
            default: load_fmt = lane;
        endcase
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next = state;
        timed_out  = (count == LAST_COUNT);
        busy       = (state == BUS);
        mem_req    = (state == BUS);
        done       = (state == RESP);
        case (state)
            IDLE: if (accept) state_next = legal ? BUS : RESP;
            BUS:  if (mem_ack || timed_out) state_next = RESP;
            RESP: begin
                if (accept) state_next = legal ? BUS : RESP;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Bus wait counter: zero outside BUS, counts cycles spent waiting for ack.
    always_ff @(posedge clk) begin
        if (rst)                count <= 8'd0;
        else if (state == BUS)  count <= count + 8'd1;
        else                    count <= 8'd0;
    end

    // Fault flag accompanying the done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= 1'b0;
            if (state == BUS && !mem_ack && timed_out) fault <= 1'b1;
            if (accept && !legal)                      fault <= 1'b1;
        end
    end

    // Capture the bus request on acceptance and hold it for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_be      <= 4'h0;
            mem_wdata   <= 32'h0;
            pend_funct3 <= 3'b000;
            pend_offset <= 2'b00;
        end else if (accept && legal) begin
            mem_we      <= is_store;
            mem_addr    <= {addr[31:2], 2'b00};
            mem_be      <= be_calc;
            mem_wdata   <= is_store ? wdata_calc : 32'h0;
            pend_funct3 <= funct3;
            pend_offset <= addr[1:0];
        end
    end

    // Load result only changes on an acknowledged load.
    always_ff @(posedge clk) begin
        if (rst)                                   load_data <= 32'h0;
        else if (state == BUS && mem_ack && !mem_we) load_data <= load_fmt;
    end

endmodule
